// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the 4-input select_bus mux: one owner at a time,
// tenure capped at MAX_HOLD cycles, one dead cycle between successive owners.
module bus_arbiter_rr #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       enable,
    output logic       timeout,
    output logic       busy
);
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TURN
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_gnt;
    logic [3:0]    w_gnt_next;
    logic [1:0]    r_sel;
    logic [1:0]    w_sel_next;
    logic          r_enable;
    logic          w_enable_next;
    logic          r_timeout;
    logic          w_timeout_next;
    logic          r_busy;
    logic          w_busy_next;
    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] w_hold_cnt_next;
    logic [1:0]    r_last_owner;
    logic [1:0]    w_last_owner_next;

    logic          w_any;
    logic [1:0]    w_win;
    logic [1:0]    w_idx;

    // Scan from last_owner+1 upward; iterating the nearest candidate last lets it win.
    always_comb begin
        w_any = |req;
        w_win = 2'd0;
        w_idx = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            w_idx = r_last_owner + 2'(i);
            if (req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_gnt_next        = r_gnt;
        w_sel_next        = r_sel;
        w_enable_next     = r_enable;
        w_timeout_next    = 1'b0;
        w_busy_next       = r_busy;
        w_hold_cnt_next   = r_hold_cnt;
        w_last_owner_next = r_last_owner;

        case (r_state)
            ST_GRANT: begin
                if (req[r_sel] && (r_hold_cnt < CW'(MAX_HOLD))) begin
                    w_hold_cnt_next = r_hold_cnt + CW'(1);
                end else begin
                    // Still requesting here means the tenure hit the cap.
                    w_state_next      = ST_TURN;
                    w_gnt_next        = 4'b0000;
                    w_enable_next     = 1'b0;
                    w_busy_next       = 1'b1;
                    w_last_owner_next = r_sel;
                    w_timeout_next    = req[r_sel];
                end
            end
            default: begin
                if (w_any) begin
                    w_state_next    = ST_GRANT;
                    w_gnt_next      = 4'b0001 << w_win;
                    w_sel_next      = w_win;
                    w_enable_next   = 1'b1;
                    w_busy_next     = 1'b1;
                    w_hold_cnt_next = CW'(1);
                end else begin
                    w_state_next  = ST_IDLE;
                    w_gnt_next    = 4'b0000;
                    w_enable_next = 1'b0;
                    w_busy_next   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_gnt        <= 4'b0000;
            r_sel        <= 2'd0;
            r_enable     <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
            r_hold_cnt   <= '0;
            r_last_owner <= 2'd3;
        end else begin
            r_state      <= w_state_next;
            r_gnt        <= w_gnt_next;
            r_sel        <= w_sel_next;
            r_enable     <= w_enable_next;
            r_timeout    <= w_timeout_next;
            r_busy       <= w_busy_next;
            r_hold_cnt   <= w_hold_cnt_next;
            r_last_owner <= w_last_owner_next;
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign enable  = r_enable;
    assign timeout = r_timeout;
    assign busy    = r_busy;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic, all compared
// against a tenure-level behavioural model of owner / gap / rotation rules.
module tb_bus_arbiter_rr;
    localparam int MAX = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       enable;
    logic       timeout;
    logic       busy;

    int checks;
    int failures;
    int cyc;
    bit verbose;

    bus_arbiter_rr #(.MAX_HOLD(MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .enable  (enable),
        .timeout (timeout),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: owner index (-1 = nobody), tenure length, whether the previous cycle
    // released the bus (gap), last released owner, and the sel value last granted.
    int m_owner;
    int m_tenure;
    int m_last;
    int m_sel;
    bit m_gap;
    bit m_to;

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_last   = 3;
        m_sel    = 0;
        m_gap    = 1'b0;
        m_to     = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (r[m_owner] && m_tenure < MAX) begin
                m_tenure++;
            end else begin
                m_to    = r[m_owner];
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else begin
            m_gap = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (r[c]) begin
                    m_owner  = c;
                    m_tenure = 1;
                    m_sel    = c;
                    break;
                end
            end
        end
    endtask

    function automatic logic [8:0] exp_vec();
        logic [3:0] g;
        logic       own;
        own = (m_owner >= 0);
        g   = own ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 2'(m_sel), own, m_to, own || m_gap};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {gnt, sel, enable, timeout, busy};
    endfunction

    task automatic tick();
        model_step(req);
        @(posedge clk);
        #1;
        cyc++;
        if (verbose && enable) $display("cyc=%0d req=%b gnt=%b sel=%0d timeout=%b", cyc, req, gnt, sel, timeout);
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (dut_vec() !== 9'b0) begin
                failures++;
                $display("FAIL reset_hold got=%b exp=%b", dut_vec(), 9'b0);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'b00 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=%b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        int en_cycles;
        int to_seen;
        en_cycles = 0;
        to_seen   = 0;
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) req = 4'b0000;
            tick();
            en_cycles += int'(enable);
            to_seen   += int'(timeout);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (i == 0) begin
                checks++;
                if (gnt !== 4'b0100 || sel !== 2'b10) begin
                    failures++;
                    $display("FAIL single_grant got gnt=%b sel=%b exp gnt=0100 sel=10", gnt, sel);
                end
            end
        end
        checks++;
        if (en_cycles != 2 || to_seen != 0) begin
            failures++;
            $display("FAIL single_tenure got en=%0d to=%0d exp en=2 to=0", en_cycles, to_seen);
        end
    endtask

    task automatic test_contention();
        logic [3:0] order[$];
        logic       prev_en;
        int         to_cnt;
        to_cnt  = 0;
        prev_en = 1'b0;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (enable && !prev_en) order.push_back(gnt);
            prev_en = enable;
            to_cnt += int'(timeout);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL contention cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (order.size() != 5 || order[0] !== 4'b0001 || order[1] !== 4'b0010 ||
            order[2] !== 4'b0100 || order[3] !== 4'b1000 || order[4] !== 4'b0001) begin
            failures++;
            $display("FAIL contention_order got n=%0d first=%b exp n=5 order 0001,0010,0100,1000,0001",
                     order.size(), (order.size() > 0) ? order[0] : 4'bx);
        end
        checks++;
        if (to_cnt != 5) begin
            failures++;
            $display("FAIL contention_timeouts got=%0d exp=5", to_cnt);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] pat[6];
        logic [3:0] want[6];
        pat  = '{4'b1011, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0001};
        want = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
        do_reset();
        req = 4'b0010;
        tick();
        for (int i = 0; i < 6; i++) begin
            req = pat[i];
            tick();
            checks++;
            if (gnt !== want[i] || dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rotation step=%0d got=%b gnt_exp=%b model_exp=%b", i, dut_vec(), want[i], exp_vec());
            end
        end
        checks++;
        if (sel !== 2'b00) begin
            failures++;
            $display("FAIL rotation_sel got=%b exp=00", sel);
        end
    endtask

    task automatic test_timeout_single();
        logic [9:0] en_pat;
        logic [9:0] to_pat;
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            en_pat = {en_pat[8:0], enable};
            to_pat = {to_pat[8:0], timeout};
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL timeout_single cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (en_pat !== 10'b1111011110 || to_pat !== 10'b0000100001) begin
            failures++;
            $display("FAIL timeout_pattern got en=%b to=%b exp en=1111011110 to=0000100001", en_pat, to_pat);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL async_setup got gnt=%b exp=0100", gnt);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 9'b0) begin
            failures++;
            $display("FAIL async_reset_immediate got=%b exp=%b", dut_vec(), 9'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b0110;
        tick();
        checks++;
        if (gnt !== 4'b0010 || sel !== 2'b01 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL async_priority got=%b exp gnt=0010 sel=01 model=%b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) req = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d req=%b got=%b exp=%b", cyc, req, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        verbose  = 1'b1;
        rst      = 1'b1;
        req      = 4'b0000;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_timeout_single();
        test_async_reset();
        verbose = 1'b0;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
